// File: rtl/uart_rx_fsm.sv
// ---------------------------------------------------------------------------
// uart_rx_fsm
//   Control FSM of an oversampling UART receiver. Tracks the position inside
//   the frame (edge_cnt within a bit, bit_cnt within the frame), tells the
//   deserializer when to store each data bit, checks parity and stop bit,
//   and pulses data_valid when a frame completes cleanly.
//
// Ports
//   CLK          oversampling clock, rising edge
//   RST          asynchronous reset, active low
//   RX_IN        serial line (idle high), already synchronised
//   PRESCALE     oversampling ratio (8, 16 or 32)
//   PAR_EN       parity bit present after the data bits
//   PAR_TYP      0 = even parity, 1 = odd parity
//   sampled_bit  majority-voted bit from the data sampler
//   dat_samp_en  data sampler enable (high whenever a frame is in progress)
//   edge_cnt     oversample index within the current bit
//   bit_cnt      frame bit index: 0 idle, 1 start, 2..9 data, 10/11 parity/stop
//   deser_en     one-cycle strobe: store sampled_bit at index bit_cnt-2
//   par_err      parity mismatch in the current/last frame
//   stop_err     stop bit sampled low in the current/last frame
//   data_valid   one-cycle pulse at the end of an error-free frame
// ---------------------------------------------------------------------------
module uart_rx_fsm #(
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic                  deser_en,
    output logic                  par_err,
    output logic                  stop_err,
    output logic                  data_valid
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state_reg, state_next;
    logic [PRESCALE_W-1:0] edge_cnt_reg, edge_cnt_next;
    logic [3:0]            bit_cnt_reg, bit_cnt_next;
    logic                  par_acc_reg, par_acc_next;
    logic                  par_err_reg, par_err_next;
    logic                  stop_err_reg, stop_err_next;
    logic                  par_en_reg, par_en_next;
    logic                  par_typ_reg, par_typ_next;
    logic                  enter_start;
    logic                  check_pt;
    logic                  bit_end;

    // The sampler needs a couple of cycles after mid-bit to finish its vote,
    // so the decision point sits two samples past the bit centre.
    assign check_pt = (edge_cnt_reg == (PRESCALE >> 1) + PRESCALE_W'(2));
    assign bit_end  = (edge_cnt_reg == PRESCALE - PRESCALE_W'(1));

    // State and datapath registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg    <= IDLE;
            edge_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            par_acc_reg  <= 1'b0;
            par_err_reg  <= 1'b0;
            stop_err_reg <= 1'b0;
            par_en_reg   <= 1'b0;
            par_typ_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            edge_cnt_reg <= edge_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            par_acc_reg  <= par_acc_next;
            par_err_reg  <= par_err_next;
            stop_err_reg <= stop_err_next;
            par_en_reg   <= par_en_next;
            par_typ_reg  <= par_typ_next;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_next    = state_reg;
        edge_cnt_next = bit_end ? '0 : edge_cnt_reg + PRESCALE_W'(1);
        bit_cnt_next  = bit_end ? bit_cnt_reg + 4'd1 : bit_cnt_reg;
        par_acc_next  = par_acc_reg;
        par_err_next  = par_err_reg;
        stop_err_next = stop_err_reg;
        par_en_next   = par_en_reg;
        par_typ_next  = par_typ_reg;
        enter_start   = 1'b0;

        case (state_reg)
            IDLE: begin
                edge_cnt_next = '0;
                bit_cnt_next  = 4'd0;
                if (!RX_IN) begin
                    state_next  = START;
                    enter_start = 1'b1;
                end
            end
            START: begin
                // A start bit that reads high at mid-bit was a line glitch
                if (check_pt && sampled_bit) begin
                    state_next    = IDLE;
                    edge_cnt_next = '0;
                    bit_cnt_next  = 4'd0;
                end else if (bit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (check_pt) begin
                    par_acc_next = par_acc_reg ^ sampled_bit;
                end
                if (bit_end && (bit_cnt_reg == 4'd9)) begin
                    state_next = par_en_reg ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (check_pt) begin
                    par_err_next = (sampled_bit != (par_acc_reg ^ par_typ_reg));
                end
                if (bit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (check_pt) begin
                    stop_err_next = !sampled_bit;
                end
                if (bit_end) begin
                    // A low line here is the next start bit already under way
                    if (!RX_IN) begin
                        state_next  = START;
                        enter_start = 1'b1;
                    end else begin
                        state_next    = IDLE;
                        edge_cnt_next = '0;
                        bit_cnt_next  = 4'd0;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                edge_cnt_next = '0;
                bit_cnt_next  = 4'd0;
            end
        endcase

        // Every frame starts from a clean slate with its own framing options
        if (enter_start) begin
            edge_cnt_next = '0;
            bit_cnt_next  = 4'd1;
            par_acc_next  = 1'b0;
            par_err_next  = 1'b0;
            stop_err_next = 1'b0;
            par_en_next   = PAR_EN;
            par_typ_next  = PAR_TYP;
        end
    end

    // Output logic
    always_comb begin
        dat_samp_en = (state_reg != IDLE);
        deser_en    = (state_reg == DATA) && check_pt;
        // stop_err for this frame was captured at the check point, earlier
        // in the same stop bit, so the register is already current here.
        data_valid  = (state_reg == STOP) && bit_end && !par_err_reg && !stop_err_reg;
        edge_cnt    = edge_cnt_reg;
        bit_cnt     = bit_cnt_reg;
        par_err     = par_err_reg;
        stop_err    = stop_err_reg;
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       sampled_bit;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       deser_en;
    logic       par_err;
    logic       stop_err;
    logic       data_valid;

    // Ideal sampler: the line value itself is the voted bit.
    assign sampled_bit = rx;

    uart_rx_fsm #(.PRESCALE_W(6)) dut (
        .CLK         (clk),
        .RST         (rst),
        .RX_IN       (rx),
        .PRESCALE    (prescale),
        .PAR_EN      (par_en),
        .PAR_TYP     (par_typ),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .deser_en    (deser_en),
        .par_err     (par_err),
        .stop_err    (stop_err),
        .data_valid  (data_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int   cyc;
        int   bitn;
        logic val;
    } deser_t;

    typedef struct {
        int   cyc;
        logic dv;
        logic pe;
        logic se;
    } frame_t;

    deser_t dq[$];
    frame_t fq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard consumer: sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        deser_t d;
        frame_t f;
        if (rst === 1'b1) begin
            if (dq.size() > 0 && cyc == dq[0].cyc) begin
                d = dq.pop_front();
                chk("deser_en", {31'd0, deser_en}, 32'd1);
                chk("deser_bit_cnt", {28'd0, bit_cnt}, d.bitn);
                chk("deser_bit", {31'd0, sampled_bit}, {31'd0, d.val});
            end else begin
                chk("deser_quiet", {31'd0, deser_en}, 32'd0);
            end
            if (fq.size() > 0 && cyc == fq[0].cyc) begin
                f = fq.pop_front();
                chk("frame_data_valid", {31'd0, data_valid}, {31'd0, f.dv});
                chk("frame_par_err", {31'd0, par_err}, {31'd0, f.pe});
                chk("frame_stop_err", {31'd0, stop_err}, {31'd0, f.se});
            end else begin
                chk("dv_quiet", {31'd0, data_valid}, 32'd0);
            end
        end
    end

    // Drives one frame starting right now and queues what the FSM must do.
    task automatic send_frame(input int p, input bit pe, input bit pt, input logic [7:0] data,
                              input bit bad_par, input bit stop_val, input bit idle_after);
        int     n0;
        bit     pbit;
        bit     exp_pe;
        bit     exp_se;
        deser_t d;
        frame_t f;
        prescale = 6'(p);
        par_en   = pe;
        par_typ  = pt;
        n0       = cyc;
        pbit     = (^data) ^ pt ^ bad_par;
        exp_pe   = pe & bad_par;
        exp_se   = !stop_val;
        for (int i = 0; i < 8; i++) begin
            d.cyc  = n0 + 1 + (i + 1) * p + p / 2 + 2;
            d.bitn = i + 2;
            d.val  = data[i];
            dq.push_back(d);
        end
        f.cyc = n0 + (10 + int'(pe)) * p;
        f.dv  = !exp_pe && !exp_se;
        f.pe  = exp_pe;
        f.se  = exp_se;
        fq.push_back(f);
        rx = 1'b0;
        tick_n(p);
        // Framing options flipped mid-frame must not be picked up
        par_en  = !pe;
        par_typ = !pt;
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            tick_n(p);
        end
        if (pe) begin
            rx = pbit;
            tick_n(p);
        end
        par_en  = pe;
        par_typ = pt;
        rx = stop_val;
        tick_n(p);
        if (idle_after) begin
            rx = 1'b1;
            tick_n(p);
        end
    endtask

    initial begin
        int          n0;
        int          guard;
        logic [7:0]  rdata;
        deser_t      d;

        rst      = 1'b1;
        rx       = 1'b1;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        prescale = 6'd8;
        #1 rst = 1'b0;
        #2;
        chk("rst_dat_samp_en", {31'd0, dat_samp_en}, 32'd0);
        chk("rst_deser_en", {31'd0, deser_en}, 32'd0);
        chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_par_err", {31'd0, par_err}, 32'd0);
        chk("rst_stop_err", {31'd0, stop_err}, 32'd0);
        chk("rst_edge_cnt", {26'd0, edge_cnt}, 32'd0);
        chk("rst_bit_cnt", {28'd0, bit_cnt}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick_n(3);
        chk("idle_after_rst", {31'd0, dat_samp_en}, 32'd0);

        // 0xA5, no parity, PRESCALE 8
        send_frame(8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1);

        // 0x37 even parity: correct parity bit, then wrong parity bit
        send_frame(16, 1'b1, 1'b0, 8'h37, 1'b0, 1'b1, 1'b1);
        send_frame(16, 1'b1, 1'b0, 8'h37, 1'b1, 1'b1, 1'b1);
        tick_n(5);
        chk("par_err_hold", {31'd0, par_err}, 32'd1);

        // Glitch: line low 3 cycles then high
        prescale = 6'd8;
        rx = 1'b0;
        tick_n(3);
        rx = 1'b1;
        tick_n(4);
        chk("glitch_in_start", {31'd0, dat_samp_en}, 32'd1);
        chk("glitch_check_edge", {26'd0, edge_cnt}, 32'd6);
        tick_n(1);
        chk("glitch_idle", {31'd0, dat_samp_en}, 32'd0);
        chk("glitch_bit_cnt", {28'd0, bit_cnt}, 32'd0);
        chk("glitch_edge_cnt", {26'd0, edge_cnt}, 32'd0);
        tick_n(8);

        // Stop bit low at PRESCALE 32, then a good frame clears the flag
        send_frame(32, 1'b0, 1'b0, 8'h5C, 1'b0, 1'b0, 1'b1);
        chk("stop_err_hold", {31'd0, stop_err}, 32'd1);
        send_frame(32, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1);

        // Back-to-back frames, odd parity
        send_frame(8, 1'b1, 1'b1, 8'h96, 1'b0, 1'b1, 1'b0);
        send_frame(8, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1);

        // Reset while bit_cnt is 5
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        rdata    = 8'h6B;
        n0       = cyc;
        for (int i = 0; i < 3; i++) begin
            d.cyc  = n0 + 1 + (i + 1) * 8 + 6;
            d.bitn = i + 2;
            d.val  = rdata[i];
            dq.push_back(d);
        end
        rx = 1'b0;
        tick_n(8);
        for (int i = 0; i < 3; i++) begin
            rx = rdata[i];
            tick_n(8);
        end
        rx = rdata[3];
        tick_n(2);
        chk("pre_rst_bit_cnt", {28'd0, bit_cnt}, 32'd5);
        chk("pre_rst_edge_cnt", {26'd0, edge_cnt}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_dat_samp_en", {31'd0, dat_samp_en}, 32'd0);
        chk("mid_rst_deser_en", {31'd0, deser_en}, 32'd0);
        chk("mid_rst_data_valid", {31'd0, data_valid}, 32'd0);
        chk("mid_rst_par_err", {31'd0, par_err}, 32'd0);
        chk("mid_rst_stop_err", {31'd0, stop_err}, 32'd0);
        chk("mid_rst_edge_cnt", {26'd0, edge_cnt}, 32'd0);
        chk("mid_rst_bit_cnt", {28'd0, bit_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rx  = 1'b1;
        rst = 1'b1;
        tick_n(4);
        chk("post_rst_idle", {31'd0, dat_samp_en}, 32'd0);
        send_frame(8, 1'b0, 1'b0, rdata, 1'b0, 1'b1, 1'b1);

        guard = 0;
        while ((dq.size() > 0 || fq.size() > 0) && guard < 1000) begin
            tick_n(1);
            guard++;
        end
        chk("scoreboard_drained", dq.size() + fq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
